wave_mixer: RTL

Parametrised, pipelined successor to the two-input clocked adder. Sums CHANNELS signed wave samples through a registered adder tree, with these additions:
- per-channel active gating
- sum or average mode
- saturation and clip detection
- valid/active flags carried through the pipeline

Sits between the per-voice wave generators and the output DAC/serialiser.

---
 rtl/wave_mixer.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/wave_mixer.sv
`default_nettype none
// ============================================================================
//  Module      : wave_mixer
//  Description : Pipelined signed mixer. Sums CHANNELS gated wave samples
//                through a registered adder tree, then applies sum (with
//                saturate/wrap) or average mode. Valid, mode and the
//                active summary ride alongside each sample.
//  Revision    : 1.0  initial release
// ============================================================================
module wave_mixer #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int SATURATE = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [CHANNELS*WIDTH-1:0]    samples,
    input  logic [CHANNELS-1:0]          active,
    input  logic                         in_valid,
    input  logic                         mode,
    input  logic                         clr_clip,
    output logic [WIDTH-1:0]             mix,
    output logic                         out_valid,
    output logic                         active_all,
    output logic                         active_any,
    output logic                         clip,
    output logic                         clip_sticky
);

    localparam int c_log2_ch = $clog2(CHANNELS);
    localparam int c_sum_w   = WIDTH + c_log2_ch;

    // Legal WIDTH-bit range expressed at full-sum width for overflow tests.
    localparam logic signed [c_sum_w-1:0] c_sum_max =
        {{(c_log2_ch + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
    localparam logic signed [c_sum_w-1:0] c_sum_min =
        {{(c_log2_ch + 1){1'b1}}, {(WIDTH - 1){1'b0}}};
    localparam logic [WIDTH-1:0] c_mix_max = {1'b0, {(WIDTH - 1){1'b1}}};
    localparam logic [WIDTH-1:0] c_mix_min = {1'b1, {(WIDTH - 1){1'b0}}};

    // Adder tree laid out as a binary heap: node n has children 2n and 2n+1,
    // leaves occupy CHANNELS..2*CHANNELS-1, node 1 is the full sum. Every
    // node is presented sign-extended to the full-sum width so that parents
    // can simply truncate to their own width.
    logic signed [c_sum_w-1:0] node_w [1:2*CHANNELS-1];

    // Leaves: gate each channel with its active bit before the first adder.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_leaf
        assign node_w[CHANNELS + i] = active[i]
            ? {{c_log2_ch{samples[i*WIDTH + WIDTH - 1]}}, samples[i*WIDTH +: WIDTH]}
            : '0;
    end

    // Internal nodes: a node at depth d sits on tree level log2(CHANNELS)-d
    // and holds a WIDTH+level bit sum, which cannot overflow.
    for (genvar n = 1; n < CHANNELS; n++) begin : g_node
        localparam int c_node_w = c_sum_w - ($clog2(n + 1) - 1);

        logic signed [c_node_w-1:0] sum_d;
        logic signed [c_node_w-1:0] sum_q;

        // Pairwise sum of the two children at this level's precision.
        always_comb begin
            sum_d = c_node_w'(node_w[2*n] + node_w[2*n + 1]);
        end

        // Tree level register.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                sum_q <= '0;
            end else begin
                sum_q <= sum_d;
            end
        end

        if (c_node_w < c_sum_w) begin : g_ext
            assign node_w[n] = {{(c_sum_w - c_node_w){sum_q[c_node_w-1]}}, sum_q};
        end else begin : g_full
            assign node_w[n] = sum_q;
        end
    end

    // Sideband delay line, one stage per tree level, so each flag leaves the
    // tree together with the sum it belongs to.
    logic [c_log2_ch-1:0] vld_pipe_d,  vld_pipe_q;
    logic [c_log2_ch-1:0] mode_pipe_d, mode_pipe_q;
    logic [c_log2_ch-1:0] all_pipe_d,  all_pipe_q;
    logic [c_log2_ch-1:0] any_pipe_d,  any_pipe_q;

    // Shift the sideband flags one stage per cycle.
    always_comb begin
        vld_pipe_d     = vld_pipe_q;
        mode_pipe_d    = mode_pipe_q;
        all_pipe_d     = all_pipe_q;
        any_pipe_d     = any_pipe_q;
        vld_pipe_d[0]  = in_valid;
        mode_pipe_d[0] = mode;
        all_pipe_d[0]  = &active;
        any_pipe_d[0]  = |active;
        for (int i = 1; i < c_log2_ch; i++) begin
            vld_pipe_d[i]  = vld_pipe_q[i-1];
            mode_pipe_d[i] = mode_pipe_q[i-1];
            all_pipe_d[i]  = all_pipe_q[i-1];
            any_pipe_d[i]  = any_pipe_q[i-1];
        end
    end

    // Sideband registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe_q  <= '0;
            mode_pipe_q <= '0;
            all_pipe_q  <= '0;
            any_pipe_q  <= '0;
        end else begin
            vld_pipe_q  <= vld_pipe_d;
            mode_pipe_q <= mode_pipe_d;
            all_pipe_q  <= all_pipe_d;
            any_pipe_q  <= any_pipe_d;
        end
    end

    logic signed [c_sum_w-1:0] sum_w;
    logic                      ovf_w;
    logic                      vld_w;
    logic                      mode_w;

    logic [WIDTH-1:0] mix_d,         mix_q;
    logic             out_valid_d,   out_valid_q;
    logic             active_all_d,  active_all_q;
    logic             active_any_d,  active_any_q;
    logic             clip_d,        clip_q;
    logic             clip_sticky_d, clip_sticky_q;

    // Output stage: average/sum selection, saturation, clip and sticky flag.
    always_comb begin
        sum_w  = node_w[1];
        vld_w  = vld_pipe_q[c_log2_ch-1];
        mode_w = mode_pipe_q[c_log2_ch-1];
        ovf_w  = (sum_w > c_sum_max) || (sum_w < c_sum_min);

        mix_d = WIDTH'(sum_w);
        if (mode_w) begin
            // Arithmetic shift gives floor division; inactive channels still
            // count in the divisor.
            mix_d = WIDTH'(sum_w >>> c_log2_ch);
        end else if (ovf_w && (SATURATE != 0)) begin
            mix_d = sum_w[c_sum_w-1] ? c_mix_min : c_mix_max;
        end

        out_valid_d   = vld_w;
        active_all_d  = vld_w & all_pipe_q[c_log2_ch-1];
        active_any_d  = vld_w & any_pipe_q[c_log2_ch-1];
        clip_d        = vld_w & ~mode_w & ovf_w;
        // A new clip takes priority over a simultaneous clear.
        clip_sticky_d = clip_d | (clip_sticky_q & ~clr_clip);
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mix_q         <= '0;
            out_valid_q   <= 1'b0;
            active_all_q  <= 1'b0;
            active_any_q  <= 1'b0;
            clip_q        <= 1'b0;
            clip_sticky_q <= 1'b0;
        end else begin
            mix_q         <= mix_d;
            out_valid_q   <= out_valid_d;
            active_all_q  <= active_all_d;
            active_any_q  <= active_any_d;
            clip_q        <= clip_d;
            clip_sticky_q <= clip_sticky_d;
        end
    end

    assign mix         = mix_q;
    assign out_valid   = out_valid_q;
    assign active_all  = active_all_q;
    assign active_any  = active_any_q;
    assign clip        = clip_q;
    assign clip_sticky = clip_sticky_q;

endmodule
`default_nettype wire
